// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// latches the returned word, and traps misaligned, out-of-range or stalled fetches.
module pc_fetch #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = W'(32'h00000000),
  parameter logic [W-1:0] PC_LIMIT = W'(32'h003FFFFC),
  parameter int           TIMEOUT  = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] next_pc_in,
  input  logic         stall_in,
  input  logic         imem_ready_in,
  input  logic [W-1:0] imem_data_in,
  output logic         imem_req_out,
  output logic [W-1:0] imem_addr_out,
  output logic [W-1:0] pc_out,
  output logic [W-1:0] pc_plus4_out,
  output logic [W-1:0] instr_out,
  output logic         instr_valid_out,
  output logic         fault_out,
  output logic [1:0]   fault_code_out
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_RANGE     = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b11;

  // The counter only has to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that raises the fault instead.
  localparam int            CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [W-1:0]  pc_reg, pc_next;
  logic [W-1:0]  instr_reg, instr_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]    fault_code_reg, fault_code_next;

  logic next_pc_misaligned;
  logic next_pc_out_of_range;

  assign next_pc_misaligned   = (next_pc_in[1:0] != 2'b00);
  assign next_pc_out_of_range = (next_pc_in > PC_LIMIT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      instr_reg      <= '0;
      wait_cnt_reg   <= '0;
      fault_code_reg <= CODE_NONE;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      wait_cnt_reg   <= wait_cnt_next;
      fault_code_reg <= fault_code_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    wait_cnt_next   = wait_cnt_reg;
    fault_code_next = fault_code_reg;

    unique case (state_reg)
      BOOT: begin
        state_next    = FETCH;
        wait_cnt_next = '0;
      end

      FETCH: begin
        if (imem_ready_in) begin
          instr_next    = imem_data_in;
          wait_cnt_next = '0;
          state_next    = HOLD;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          fault_code_next = CODE_TIMEOUT;
          state_next      = FAULT;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end

      HOLD: begin
        // A rejected next PC leaves pc_reg on the instruction that was issued.
        if (!stall_in) begin
          if (next_pc_misaligned) begin
            fault_code_next = CODE_MISALIGN;
            state_next      = FAULT;
          end else if (next_pc_out_of_range) begin
            fault_code_next = CODE_RANGE;
            state_next      = FAULT;
          end else begin
            pc_next       = next_pc_in;
            wait_cnt_next = '0;
            state_next    = FETCH;
          end
        end
      end

      FAULT: begin
        state_next = FAULT;
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Outputs decode straight from registers so reset clears them without a clock.
  assign imem_req_out    = (state_reg == FETCH);
  assign imem_addr_out   = pc_reg;
  assign pc_out          = pc_reg;
  assign pc_plus4_out    = pc_reg + W'(4);
  assign instr_out       = instr_reg;
  assign instr_valid_out = (state_reg == HOLD);
  assign fault_out       = (state_reg == FAULT);
  assign fault_code_out  = fault_code_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: a cycle-level reference model of the fetch
// rules is compared against the DUT on every falling edge, plus directed scenarios.
module tb_pc_fetch;

  localparam logic [31:0] LIMIT   = 32'h003FFFFC;
  localparam int          TMO     = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] next_pc_in = '0;
  logic        stall_in = 1'b0;
  logic        imem_ready_in = 1'b0;
  logic [31:0] imem_data_in = '0;

  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        fault_out;
  logic [1:0]  fault_code_out;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_fault;
  logic [1:0]  w_code;

  always #5 clk_in = ~clk_in;

  pc_fetch dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .next_pc_in      (next_pc_in),
    .stall_in        (stall_in),
    .imem_ready_in   (imem_ready_in),
    .imem_data_in    (imem_data_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .instr_out       (instr_out),
    .instr_valid_out (instr_valid_out),
    .fault_out       (fault_out),
    .fault_code_out  (fault_code_out)
  );

  // Second instance parked at the top of the address space to see pc+4 wrap.
  pc_fetch #(.W(32), .RESET_PC(32'hFFFFFFFC), .PC_LIMIT(32'hFFFFFFFC)) u_wrap (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .next_pc_in      (next_pc_in),
    .stall_in        (stall_in),
    .imem_ready_in   (imem_ready_in),
    .imem_data_in    (imem_data_in),
    .imem_req_out    (w_req),
    .imem_addr_out   (w_addr),
    .pc_out          (w_pc),
    .pc_plus4_out    (w_pc4),
    .instr_out       (w_instr),
    .instr_valid_out (w_valid),
    .fault_out       (w_fault),
    .fault_code_out  (w_code)
  );

  // Reference model: which phase the fetcher is in, what it fetched, how long it waited.
  localparam int P_BOOT  = 0;
  localparam int P_FETCH = 1;
  localparam int P_HOLD  = 2;
  localparam int P_FAULT = 3;

  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_waited;
  logic [1:0]  m_code;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_phase  <= P_BOOT;
      m_pc     <= 32'h0;
      m_instr  <= 32'h0;
      m_waited <= 0;
      m_code   <= 2'd0;
    end else begin
      case (m_phase)
        P_BOOT: begin
          m_phase  <= P_FETCH;
          m_waited <= 0;
        end
        P_FETCH: begin
          if (imem_ready_in) begin
            m_instr <= imem_data_in;
            m_phase <= P_HOLD;
          end else if (m_waited + 1 >= TMO) begin
            m_phase <= P_FAULT;
            m_code  <= 2'd3;
          end else begin
            m_waited <= m_waited + 1;
          end
        end
        P_HOLD: begin
          if (!stall_in) begin
            if ((next_pc_in % 4) != 0) begin
              m_phase <= P_FAULT;
              m_code  <= 2'd1;
            end else if (next_pc_in > LIMIT) begin
              m_phase <= P_FAULT;
              m_code  <= 2'd2;
            end else begin
              m_pc     <= next_pc_in;
              m_phase  <= P_FETCH;
              m_waited <= 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic compare_model();
    chk("req",   {31'd0, imem_req_out},    {31'd0, m_phase == P_FETCH});
    chk("addr",  imem_addr_out,            m_pc);
    chk("pc",    pc_out,                   m_pc);
    chk("pc4",   pc_plus4_out,             m_pc + 32'd4);
    chk("valid", {31'd0, instr_valid_out}, {31'd0, m_phase == P_HOLD});
    if (m_phase == P_HOLD) chk("instr", instr_out, m_instr);
    chk("fault", {31'd0, fault_out},       {31'd0, m_phase == P_FAULT});
    chk("code",  {30'd0, fault_code_out},  {30'd0, m_code});
  endtask

  task automatic step();
    @(negedge clk_in);
    compare_model();
  endtask

  task automatic idle_inputs();
    stall_in      = 1'b0;
    imem_ready_in = 1'b0;
    imem_data_in  = '0;
    next_pc_in    = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released (BOOT).
  task automatic reset_dut();
    rst_in = 1'b1;
    idle_inputs();
    step();
    rst_in = 1'b0;
  endtask

  // Leaves the bench at a falling edge in HOLD with instruction 'word' from PC 0.
  task automatic to_hold(input logic [31:0] word);
    reset_dut();
    step();
    imem_ready_in = 1'b1;
    imem_data_in  = word;
    step();
    imem_ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ready_pct;
    int r;

    // Reset release, BOOT, then first fetch.
    reset_dut();
    chk("boot_req",    {31'd0, imem_req_out}, 32'd0);
    chk("boot_pc",     pc_out, 32'h0);
    chk("boot_instr",  instr_out, 32'h0);
    chk("wrap_pc",     w_pc, 32'hFFFFFFFC);
    chk("wrap_addr",   w_addr, 32'hFFFFFFFC);
    chk("wrap_pc4",    w_pc4, 32'h0);
    chk("wrap_flags",  {24'd0, w_req, w_valid, w_fault, w_code, 3'd0}, 32'd0);
    chk("wrap_instr",  w_instr, 32'h0);
    step();
    chk("s1_req",  {31'd0, imem_req_out}, 32'd1);
    chk("s1_addr", imem_addr_out, 32'h0);
    imem_ready_in = 1'b1;
    imem_data_in  = 32'h8C010004;
    step();
    imem_ready_in = 1'b0;
    imem_data_in  = $urandom;
    chk("s1_instr", instr_out, 32'h8C010004);
    chk("s1_valid", {31'd0, instr_valid_out}, 32'd1);
    chk("s1_pc4",   pc_plus4_out, 32'h4);

    // Stall in HOLD, then release.
    stall_in   = 1'b1;
    next_pc_in = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_pc_held",    pc_out, 32'h0);
      chk("s2_valid_held", {31'd0, instr_valid_out}, 32'd1);
    end
    stall_in = 1'b0;
    step();
    chk("s2_pc_new", pc_out, 32'h40);
    chk("s2_req",    {31'd0, imem_req_out}, 32'd1);
    next_pc_in    = 32'h42;
    imem_ready_in = 1'b1;
    imem_data_in  = $urandom;
    step();
    imem_ready_in = 1'b0;

    // Misaligned next PC.
    next_pc_in = 32'h42;
    step();
    chk("s3_fault", {31'd0, fault_out}, 32'd1);
    chk("s3_code",  {30'd0, fault_code_out}, 32'd1);
    chk("s3_pc",    pc_out, 32'h40);
    step();
    chk("s3_sticky", {31'd0, fault_out}, 32'd1);

    // Range boundary.
    to_hold($urandom);
    next_pc_in = 32'h00400000;
    step();
    chk("s4_code_range", {30'd0, fault_code_out}, 32'd2);
    to_hold($urandom);
    next_pc_in = 32'h003FFFFC;
    step();
    chk("s4_pc_limit", pc_out, 32'h003FFFFC);
    chk("s4_fault0",   {31'd0, fault_out}, 32'd0);

    // Timeout at exactly TIMEOUT fetch cycles.
    reset_dut();
    step();
    repeat (TMO - 1) step();
    chk("s5_still_req", {31'd0, imem_req_out}, 32'd1);
    step();
    chk("s5_fault", {31'd0, fault_out}, 32'd1);
    chk("s5_code",  {30'd0, fault_code_out}, 32'd3);
    reset_dut();
    step();
    repeat (TMO - 1) step();
    imem_ready_in = 1'b1;
    imem_data_in  = 32'h12345678;
    step();
    imem_ready_in = 1'b0;
    chk("s5_late_ok_fault", {31'd0, fault_out}, 32'd0);
    chk("s5_late_ok_instr", instr_out, 32'h12345678);

    // Asynchronous reset mid-FETCH at PC 0x100.
    to_hold($urandom);
    next_pc_in = 32'h100;
    step();
    chk("s6_pc_before", pc_out, 32'h100);
    #2;
    rst_in = 1'b1;
    #1;
    chk("s6_async_pc",  pc_out, 32'h0);
    chk("s6_async_req", {31'd0, imem_req_out}, 32'd0);
    imem_ready_in = 1'b1;
    imem_data_in  = 32'hDEADBEEF;
    step();
    chk("s6_late_valid", {31'd0, instr_valid_out}, 32'd0);
    chk("s6_late_instr", instr_out, 32'h0);
    idle_inputs();
    rst_in = 1'b0;

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      reset_dut();
      r = ep % 3;
      ready_pct = (r == 0) ? 5 : ((r == 1) ? 50 : 90);
      for (int c = 0; c < 50; c++) begin
        stall_in      = ($urandom_range(0, 99) < 30);
        imem_ready_in = ($urandom_range(0, 99) < ready_pct);
        imem_data_in  = $urandom;
        r = $urandom_range(0, 29);
        if (r == 0)
          next_pc_in = {$urandom_range(0, 32'h000FFFFF), 2'b00} | 32'($urandom_range(1, 3));
        else if (r == 1)
          next_pc_in = ({$urandom, 2'b00} & 32'hFFFFFFFC) | 32'h00400000;
        else if (r == 2)
          next_pc_in = 32'h003FFFFC;
        else if (r == 3)
          next_pc_in = 32'h00400000;
        else
          next_pc_in = ($urandom % 32'h00100000) << 2;
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter W, default 32, datapath width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-003 The block SHALL have parameter PC_LIMIT, default 32'h003FFFFC, highest legal fetch address.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, maximum FETCH cycles without imem_ready_in.
REQ-005 The block SHALL have port clk_in, input, 1, single clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-007 The block SHALL have port next_pc_in, input, W, next PC chosen by the upstream 4:1 PC-source mux.
REQ-008 The block SHALL have port stall_in, input, 1, hold the current instruction and PC.
REQ-009 The block SHALL have port imem_ready_in, input, 1, instruction memory data valid this cycle.
REQ-010 The block SHALL have port imem_data_in, input, W, instruction word from memory.
REQ-011 The block SHALL have port imem_req_out, output, 1, fetch request.
REQ-012 The block SHALL have port imem_addr_out, output, W, fetch address, equal to pc_out.
REQ-013 The block SHALL have port pc_out, output, W, current PC register.
REQ-014 The block SHALL have port pc_plus4_out, output, W, pc_out + 4, feeding mux data0.
REQ-015 The block SHALL have port instr_out, output, W, latched instruction.
REQ-016 The block SHALL have port instr_valid_out, output, 1, instr_out is valid for pc_out.
REQ-017 The block SHALL have port fault_out, output, 1, sticky fetch fault.
REQ-018 The block SHALL have port fault_code_out, output, 2, fault cause: 01 misaligned, 10 out of range, 11 timeout, 00 none.

Function
REQ-019 The block SHALL implement states BOOT, FETCH, HOLD, FAULT.
REQ-020 BOOT SHALL last exactly one cycle with imem_req_out=0, then go to FETCH.
REQ-021 In FETCH, imem_req_out SHALL be 1 and imem_addr_out SHALL equal pc_out.
REQ-022 In FETCH with imem_ready_in=1, instr_out SHALL capture imem_data_in, instr_valid_out SHALL be 1 next cycle, and the state SHALL go to HOLD, giving 1-cycle latency from ready to valid.
REQ-023 The wait counter SHALL clear on entry to FETCH and increment each FETCH cycle with imem_ready_in=0.
REQ-024 On the TIMEOUT-th consecutive such cycle, the block SHALL enter FAULT with code 11.
REQ-025 In HOLD, imem_req_out SHALL be 0 and instr_valid_out SHALL be 1.
REQ-026 In HOLD with stall_in=1, pc_out, instr_out, and state SHALL be unchanged.
REQ-027 In HOLD with stall_in=0 and legal next_pc_in, pc_out SHALL load next_pc_in, instr_valid_out SHALL clear, and the state SHALL go to FETCH.
REQ-028 next_pc_in SHALL be legal iff bits [1:0]=00 and next_pc_in <= PC_LIMIT.
REQ-029 If next_pc_in is misaligned, the block SHALL enter FAULT with code 01; misalignment takes priority over range.
REQ-030 If next_pc_in is aligned but above PC_LIMIT, the block SHALL enter FAULT with code 10.
REQ-031 On any fault, pc_out SHALL hold the PC of the last issued instruction.
REQ-032 next_pc_in, stall_in, imem_ready_in, and imem_data_in SHALL be ignored outside their owning state.
REQ-033 FAULT SHALL be sticky until reset, with imem_req_out=0, instr_valid_out=0, and fault_out=1.
REQ-034 pc_plus4_out SHALL be combinational pc_out + 4, wrapping modulo 2^W.
REQ-035 When pc_out=32'hFFFFFFFC, pc_plus4_out SHALL be 0.

Reset
REQ-036 While rst_in=1, regardless of clock, outputs SHALL be: pc_out=RESET_PC, instr_out=0, instr_valid_out=0, imem_req_out=0, fault_out=0, fault_code_out=00, wait counter=0, state=BOOT.
REQ-037 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the fetch immediately; a late imem_ready_in SHALL have no effect.
REQ-038 After rst_in deasserts, the first request SHALL appear on the second rising edge (BOOT then FETCH).

Verification
REQ-039 Scenario: reset release, imem_ready_in=1 on first FETCH cycle, data 32'h8C010004 -> imem_addr_out=0; next cycle instr_out=32'h8C010004, instr_valid_out=1, pc_plus4_out=4.
REQ-040 Scenario: in HOLD, stall_in=1 for 3 cycles with next_pc_in=32'h40 -> pc_out stays 0 and instr_valid_out stays 1; when stall drops, pc_out=32'h40 and imem_req_out=1.
REQ-041 Scenario: next_pc_in=32'h42 in HOLD with stall_in=0 -> fault_out=1, fault_code_out=01, pc_out unchanged.
REQ-042 Scenario: next_pc_in=32'h00400000 -> fault_code_out=10; next_pc_in=32'h003FFFFC -> accepted.
REQ-043 Scenario: imem_ready_in held 0 -> FAULT with code 11 after exactly 16 FETCH cycles; ready on the 16th cycle -> no fault.
REQ-044 Scenario: rst_in pulsed asynchronously mid-FETCH with PC=32'h100 -> pc_out=0 and imem_req_out=0 immediately, without waiting for a clock edge.
